// File: rtl/calc_op_sequencer.sv
// Command front-end for the registered add/sub calculator core: one operation in flight,
// operands held steady to the core, result/status captured after the core latency.

package calculator_pkg;
   typedef enum logic {
      ADD = 1'b0,
      SUB = 1'b1
   } te_operation;

   typedef enum logic [1:0] {
      STANDBY  = 2'd0,
      VALID    = 2'd1,
      OVERFLOW = 2'd2,
      NEGATIVE = 2'd3
   } te_out_status;
endpackage

// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1;
// while valid=1 and ready=0 the producer keeps valid and its payload unchanged.
module calc_op_sequencer
   import calculator_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int LATENCY   = 1,
   parameter int ERR_W     = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [BIT_WIDTH-1:0] cmd_a,
   input  logic [BIT_WIDTH-1:0] cmd_b,
   input  te_operation          cmd_op,
   output logic [BIT_WIDTH-1:0] core_a,
   output logic [BIT_WIDTH-1:0] core_b,
   output te_operation          core_op,
   input  logic [BIT_WIDTH-1:0] core_result,
   input  te_out_status         core_status,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [BIT_WIDTH-1:0] rsp_result,
   output te_out_status         rsp_status,
   output logic [ERR_W-1:0]     err_count,
   output logic [1:0]           fsm_state
);

   localparam int CNT_W = $clog2(LATENCY + 2);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             retire;
   logic             capture;
   logic             err_hit;

   // A response retiring frees the slot in the same edge, so RESP can accept directly.
   assign cmd_ready = (state == S_IDLE) || ((state == S_RESP) && rsp_ready);
   assign accept    = cmd_valid && cmd_ready;
   assign retire    = (state == S_RESP) && rsp_ready;
   assign capture   = (state == S_WAIT) && (cnt == '0);
   assign err_hit   = capture && ((core_status == OVERFLOW) || (core_status == NEGATIVE));
   assign rsp_valid = (state == S_RESP);
   assign fsm_state = state;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_WAIT;
                  cnt   <= CNT_W'(LATENCY);
               end
            end
            S_WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               if (retire) begin
                  if (cmd_valid) begin
                     state <= S_WAIT;
                     cnt   <= CNT_W'(LATENCY);
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         core_a  <= '0;
         core_b  <= '0;
         core_op <= ADD;
      end else if (accept) begin
         core_a  <= cmd_a;
         core_b  <= cmd_b;
         core_op <= cmd_op;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_result <= '0;
         rsp_status <= STANDBY;
      end else if (capture) begin
         rsp_result <= core_result;
         rsp_status <= core_status;
      end
   end

   // Saturating: once all-ones, further errors are absorbed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         err_count <= '0;
      end else if (err_hit && (err_count != '1)) begin
         err_count <= err_count + ERR_W'(1);
      end
   end

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Bench for calc_op_sequencer: behavioural core model, table of directed vectors,
// hand-written corner sequences, randomized traffic checked by a queue scoreboard.
module tb_calc_op_sequencer;
   import calculator_pkg::*;

   localparam int BW  = 8;
   localparam int LAT = 1;

   typedef struct packed {
      te_out_status st;
      logic [BW-1:0] res;
   } exp_t;

   typedef struct {
      logic [BW-1:0] a;
      logic [BW-1:0] b;
      te_operation   op;
      logic [BW-1:0] res;
      te_out_status  st;
      int            err;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT 1 (default parameters) ----------------
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic [BW-1:0] cmd_a = '0;
   logic [BW-1:0] cmd_b = '0;
   te_operation   cmd_op = ADD;
   logic [BW-1:0] core_a;
   logic [BW-1:0] core_b;
   te_operation   core_op;
   logic [BW-1:0] core_result;
   te_out_status  core_status;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [BW-1:0] rsp_result;
   te_out_status  rsp_status;
   logic [15:0]   err_count;
   logic [1:0]    fsm_state;

   calc_op_sequencer #(.BIT_WIDTH(BW), .LATENCY(LAT), .ERR_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .core_a(core_a), .core_b(core_b), .core_op(core_op),
      .core_result(core_result), .core_status(core_status),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_status(rsp_status),
      .err_count(err_count), .fsm_state(fsm_state)
   );

   // ---------------- DUT 2 (narrow error counter for saturation) ----------------
   logic          cmd_valid2 = 1'b0;
   logic          cmd_ready2;
   logic [BW-1:0] cmd_a2 = 8'd1;
   logic [BW-1:0] cmd_b2 = 8'd2;
   te_operation   cmd_op2 = ADD;
   logic [BW-1:0] core_a2;
   logic [BW-1:0] core_b2;
   te_operation   core_op2;
   logic [BW-1:0] core_result2 = '0;
   te_out_status  core_status2 = OVERFLOW;
   logic          rsp_valid2;
   logic          rsp_ready2 = 1'b1;
   logic [BW-1:0] rsp_result2;
   te_out_status  rsp_status2;
   logic [2:0]    err_count2;
   logic [1:0]    fsm_state2;

   calc_op_sequencer #(.BIT_WIDTH(BW), .LATENCY(LAT), .ERR_W(3)) dut2 (
      .clk(clk), .reset_n(reset_n),
      .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
      .cmd_a(cmd_a2), .cmd_b(cmd_b2), .cmd_op(cmd_op2),
      .core_a(core_a2), .core_b(core_b2), .core_op(core_op2),
      .core_result(core_result2), .core_status(core_status2),
      .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
      .rsp_result(rsp_result2), .rsp_status(rsp_status2),
      .err_count(err_count2), .fsm_state(fsm_state2)
   );

   // ---------------- reference arithmetic ----------------
   function automatic exp_t model(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                  input te_operation op);
      exp_t e;
      int   r;
      if (op == ADD) begin
         r    = int'(a) + int'(b);
         e.st = (r > 255) ? OVERFLOW : VALID;
      end else begin
         r    = int'(a) - int'(b);
         e.st = (r < 0) ? NEGATIVE : VALID;
      end
      e.res = 8'(r & 255);
      return e;
   endfunction

   // Core stand-in: one register stage from operands to result/status.
   exp_t core_m;
   assign core_m = model(core_a, core_b, core_op);
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         core_result <= '0;
         core_status <= STANDBY;
      end else begin
         core_result <= core_m.res;
         core_status <= core_m.st;
      end
   end

   // ---------------- checking helpers ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: timed out (t=%0t)", nm, $time);
   endtask

   // ---------------- scoreboard monitor ----------------
   logic [9:0]    exp_q[$];
   bit            mon_en = 1'b0;
   int            m_err = 0;
   int            last_acc = 0;
   bit            prev_v = 1'b0;
   bit            hold = 1'b0;
   logic [BW-1:0] h_res;
   logic [1:0]    h_st;

   always @(negedge clk) begin
      logic [9:0] e;
      logic       exp_rdy;
      if (!reset_n) begin
         exp_q.delete();
         m_err  = 0;
         prev_v = 1'b0;
         hold   = 1'b0;
      end else if (mon_en) begin
         exp_rdy = (exp_q.size() == 0) ? 1'b1 : (rsp_valid ? rsp_ready : 1'b0);
         chk("mon_cmd_ready", cmd_ready, exp_rdy);
         if (hold) begin
            chk("mon_hold_valid", rsp_valid, 1'b1);
            chk("mon_hold_result", rsp_result, h_res);
            chk("mon_hold_status", rsp_status, h_st);
         end
         if (rsp_valid && !prev_v) begin
            if (exp_q.size() == 0) begin
               timeout_fail("mon_unexpected_rsp");
            end else begin
               chk("mon_latency", cyc - last_acc, LAT + 1);
               chk("mon_err_count", err_count, m_err);
            end
         end
         if (rsp_valid && rsp_ready && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("mon_result", rsp_result, e[7:0]);
            chk("mon_status", rsp_status, e[9:8]);
         end
         if (cmd_valid && cmd_ready) begin
            e = model(cmd_a, cmd_b, cmd_op);
            exp_q.push_back(e);
            last_acc = cyc + 1;
            if ((e[9:8] == OVERFLOW) || (e[9:8] == NEGATIVE)) begin
               m_err = (m_err == 65535) ? m_err : m_err + 1;
            end
         end
         prev_v = rsp_valid;
         hold   = rsp_valid && !rsp_ready;
         h_res  = rsp_result;
         h_st   = rsp_status;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_cmd(input logic [BW-1:0] a, input logic [BW-1:0] b,
                         input te_operation op, output int acc);
      acc       = -1;
      cmd_a     = a;
      cmd_b     = b;
      cmd_op    = op;
      cmd_valid = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (cmd_ready) begin
            @(posedge clk);
            #1;
            acc = cyc;
            break;
         end
      end
      cmd_valid = 1'b0;
      if (acc < 0) timeout_fail("cmd_accept");
   endtask

   task automatic wait_rsp(input string nm, input int acc, input logic [BW-1:0] res,
                           input te_out_status st, input int err);
      bit seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         timeout_fail({nm, "_rsp_valid"});
      end else begin
         chk({nm, "_latency"}, cyc - acc, LAT + 1);
         chk({nm, "_result"}, rsp_result, res);
         chk({nm, "_status"}, rsp_status, st);
         chk({nm, "_err"}, err_count, err);
      end
   endtask

   // ---------------- stimulus ----------------
   vec_t vecs[8];
   bit   drv_done;

   initial begin
      int acc;
      int acc0, acc1, acc2;
      int n;
      logic [BW-1:0] held;

      vecs[0] = '{a: 8'd100, b: 8'd27,  op: ADD, res: 8'd127, st: VALID,    err: 0};
      vecs[1] = '{a: 8'd200, b: 8'd100, op: ADD, res: 8'd44,  st: OVERFLOW, err: 1};
      vecs[2] = '{a: 8'd50,  b: 8'd20,  op: SUB, res: 8'd30,  st: VALID,    err: 1};
      vecs[3] = '{a: 8'd20,  b: 8'd50,  op: SUB, res: 8'd226, st: NEGATIVE, err: 2};
      vecs[4] = '{a: 8'd255, b: 8'd1,   op: ADD, res: 8'd0,   st: OVERFLOW, err: 3};
      vecs[5] = '{a: 8'd0,   b: 8'd0,   op: SUB, res: 8'd0,   st: VALID,    err: 3};
      vecs[6] = '{a: 8'd128, b: 8'd127, op: ADD, res: 8'd255, st: VALID,    err: 3};
      vecs[7] = '{a: 8'd0,   b: 8'd1,   op: SUB, res: 8'd255, st: NEGATIVE, err: 4};

      // reset values
      #1;
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_result", rsp_result, 8'd0);
      chk("rst_rsp_status", rsp_status, STANDBY);
      chk("rst_err_count", err_count, 16'd0);
      chk("rst_core_a", core_a, 8'd0);
      chk("rst_core_b", core_b, 8'd0);
      chk("rst_core_op", core_op, ADD);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      mon_en  = 1'b1;

      // directed table, consumer always ready
      rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         do_cmd(vecs[i].a, vecs[i].b, vecs[i].op, acc);
         chk("tbl_core_a", core_a, vecs[i].a);
         chk("tbl_core_b", core_b, vecs[i].b);
         chk("tbl_core_op", core_op, vecs[i].op);
         wait_rsp("tbl", acc, vecs[i].res, vecs[i].st, vecs[i].err);
         @(posedge clk);
         #1;
      end

      // consumer stalls for 5 cycles
      rsp_ready = 1'b0;
      do_cmd(8'd10, 8'd5, SUB, acc);
      wait_rsp("stall", acc, 8'd5, VALID, 4);
      held = rsp_result;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_valid", rsp_valid, 1'b1);
         chk("stall_result", rsp_result, held);
         chk("stall_status", rsp_status, VALID);
         chk("stall_cmd_ready", cmd_ready, 1'b0);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_cmd_ready", cmd_ready, 1'b1);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("stall_retired_valid", rsp_valid, 1'b0);
      chk("stall_retired_cmd_ready", cmd_ready, 1'b1);
      @(posedge clk);
      #1;

      // back-to-back with cmd_valid held
      do_cmd(8'd1, 8'd2, ADD, acc0);
      do_cmd(8'd250, 8'd10, ADD, acc1);
      do_cmd(8'd3, 8'd9, SUB, acc2);
      chk("b2b_gap1", acc1 - acc0, LAT + 2);
      chk("b2b_gap2", acc2 - acc1, LAT + 2);
      wait_rsp("b2b_last", acc2, 8'd250, NEGATIVE, 6);
      @(posedge clk);
      #1;

      // saturation on the narrow counter instance
      cmd_valid2 = 1'b1;
      n = 0;
      for (int k = 0; k < 80 && n < 10; k++) begin
         @(negedge clk);
         if (rsp_valid2) begin
            n++;
            chk("sat_err_count", err_count2, (n > 7) ? 7 : n);
            chk("sat_status", rsp_status2, OVERFLOW);
         end
      end
      cmd_valid2 = 1'b0;
      if (n < 10) timeout_fail("sat_responses");
      @(posedge clk);
      #1;

      // reset in the middle of WAIT
      do_cmd(8'd7, 8'd8, ADD, acc);
      @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", rsp_valid, 1'b0);
      chk("midrst_rsp_result", rsp_result, 8'd0);
      chk("midrst_rsp_status", rsp_status, STANDBY);
      chk("midrst_err_count", err_count, 16'd0);
      chk("midrst_core_a", core_a, 8'd0);
      chk("midrst_core_b", core_b, 8'd0);
      chk("midrst_core_op", core_op, ADD);
      chk("midrst_cmd_ready", cmd_ready, 1'b1);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("midrst_no_rsp", rsp_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      do_cmd(8'd9, 8'd9, SUB, acc);
      wait_rsp("post_rst", acc, 8'd0, VALID, 0);
      @(posedge clk);
      #1;

      // randomized traffic with random consumer backpressure
      drv_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               do_cmd(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      te_operation'($urandom_range(0, 1)), acc);
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk);
               #1;
               rsp_ready = ($urandom_range(0, 3) != 0);
            end
            rsp_ready = 1'b1;
         end
      join
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) timeout_fail("rand_drain");
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1);
   end

endmodule
